sv32_tlb: RTL and testbench
===========================

// Module: sv32_tlb
// PURPOSE
//  Fully-associative Sv32 translation buffer directly upstream of the set-associative cache.
//  Translates a virtual page number to a PPN and permissions in one registered cycle.
//  Supplies the physical tag (PPN[19:0], CACHE_TAG_WD bits) that the cache compares against.
//  Supports refill from the page-table walker and sfence.vma-style flushes.
// PARAMETERS
//  ENTRIES    32 (`TLB_ENTRY_SIZE)  number of entries; power of two, >=2
//  ASID_W     9  (`ASID_WD)         address-space id width
//  PPN_W      22 (`PPN_WD)          physical page number width
//  VPN_W      20 (`VPN1_WD+`VPN0_WD) virtual page number width; VPN1 = [19:10], VPN0 = [9:0]
// PORTS
//  clk           in   1        clock
//  rst           in   1        asynchronous reset, active-low
//  req_valid     in   1        lookup request
//  req_vpn       in   VPN_W    lookup VPN
//  req_asid      in   ASID_W   lookup ASID
//  resp_valid    out  1        lookup response, one cycle after req_valid
//  resp_hit      out  1        translation found
//  resp_ppn      out  PPN_W    translated PPN (superpage: {ppn[21:10], req_vpn[9:0]})
//  resp_ptag     out  20       resp_ppn[19:0]; physical tag for the cache
//  resp_perm     out  8        {D,A,G,U,X,W,R,V} of the hit entry; 0 on miss
//  fill_valid    in   1        write a PTE from the walker
//  fill_vpn      in   VPN_W    fill VPN
//  fill_asid     in   ASID_W   fill ASID
//  fill_ppn      in   PPN_W    fill PPN
//  fill_perm     in   8        fill permissions; entry valid only if perm[0] (V) = 1
//  fill_super    in   1        4 MiB megapage; matches on VPN1 only
//  flush_valid   in   1        sfence.vma request
//  flush_use_asid in  1        0: all ASIDs; 1: only flush_asid (global entries are kept)
//  flush_use_vpn in   1        0: all pages; 1: only entries that match flush_vpn
//  flush_asid    in   ASID_W   flush ASID
//  flush_vpn     in   VPN_W    flush VPN
//  miss_cnt      out  32       count of resp_valid & !resp_hit, wrapping
// BEHAVIOUR
//  - Reset: all entry valid bits = 0, victim pointer = 0, resp_* = 0, miss_cnt = 0.
//  - Match rule: valid & (G | asid==req_asid) & vpn1 equal & (super | vpn0 equal).
//  - Latency: response registers update on the edge after req_valid. resp_valid = 0 when req_valid was 0.
//    resp_hit, resp_ppn and resp_perm hold their last values while resp_valid = 0.
//  - Fills never create duplicates. Multiple hits must not occur. In simulation, an assertion fires on a one-hot violation.
//  - Fill placement:
//    - An entry that matches fill_vpn/fill_asid exactly (same super flag) is overwritten.
//    - Otherwise the lowest-index invalid entry is used.
//    - Otherwise the entry at the victim pointer is used, and the pointer then increments by 1, wrapping ENTRIES-1 -> 0.
//    - The pointer advances only on a victim fill.
//  - A fill with V = 0 writes nothing.
//  - Flush takes effect at the next edge and clears every selected entry. use_vpn matching respects super.
//  - Simultaneous events in one cycle:
//    - A lookup in the same cycle as a fill or flush sees the old contents (no bypass).
//    - A fill and a flush in the same cycle: the flush is applied first, then the fill. The filled entry survives.
//      Placement is computed on the post-flush valid bits.
//  - Reset asserted mid-operation: everything returns to reset values immediately. An in-flight response is lost.
//  - miss_cnt wraps from 0xFFFF_FFFF to 0.
// STRUCTURE
//  - Shared package (alongside the existing cache/TLB widths):
//    - tlb_entry_t {valid, asid, vpn, ppn, perm[7:0], super}.
//    - PERM_V..PERM_D bit-index localparams.
//  - Entry array uses the shared D_FLIP_FLOP macro (async active-low reset, enable = write).
//  - Sub-module tlb_victim_sel: given ENTRIES valid bits and the pointer, returns the write index and ptr_advance.
// TESTING
//  1 Reset, then lookup vpn=0x12345, asid=1 -> next cycle resp_valid=1, resp_hit=0, resp_perm=0, miss_cnt=1.
//  2 Fill vpn=0x12345, asid=1, ppn=0x0ABCDE, perm=0xCF. Lookup the same pair -> hit, resp_ppn=0x0ABCDE,
//    resp_ptag=0xABCDE. The same VPN with asid=2 -> miss.
//  3 Fill megapage vpn=0x40000, ppn=0x3FF000, super=1, G=1. Lookup vpn=0x40155, asid=7
//    -> hit, resp_ppn=0x3FF155.
//  4 Fill 33 distinct VPNs -> entries 0..31 fill in order. The 33rd overwrites entry 0 and the pointer becomes 1.
//    VPN #0 now misses; VPN #1 still hits.
//  5 Flush with use_asid=1, asid=1, use_vpn=0 -> asid-1 non-global entries miss; global megapage still hits.
//    Then flush with use_asid=0, use_vpn=0 -> everything misses.
//  6 In one cycle: lookup X, fill X, flush all -> that response misses. The next lookup of X hits.
//    Reset pulsed during a pending lookup -> resp_valid=0.

Source files
------------

// File: rtl/sv32_tlb_pkg.sv
// Shared TLB/cache widths, entry payload, permission bit indices and the
// common enabled flop macro. Included first; everything else imports it.
`ifndef SV32_TLB_PKG_SV
`define SV32_TLB_PKG_SV

// Enabled flop with async active-low reset; expects clk/rst in scope.
`define D_FLIP_FLOP(q, d, en, rstval) \
  always_ff @(posedge clk or negedge rst) begin \
    if (!rst) q <= (rstval); \
    else if (en) q <= (d); \
  end

package sv32_tlb_pkg;

  localparam int unsigned TLB_ENTRY_SIZE = 32;
  localparam int unsigned ASID_WD        = 9;
  localparam int unsigned PPN_WD         = 22;
  localparam int unsigned VPN1_WD        = 10;
  localparam int unsigned VPN0_WD        = 10;
  localparam int unsigned VPN_WD         = VPN1_WD + VPN0_WD;
  localparam int unsigned CACHE_TAG_WD   = 20;
  localparam int unsigned PERM_WD        = 8;

  localparam int unsigned PERM_V = 0;
  localparam int unsigned PERM_R = 1;
  localparam int unsigned PERM_W = 2;
  localparam int unsigned PERM_X = 3;
  localparam int unsigned PERM_U = 4;
  localparam int unsigned PERM_G = 5;
  localparam int unsigned PERM_A = 6;
  localparam int unsigned PERM_D = 7;

  typedef struct packed {
    logic               valid;
    logic [ASID_WD-1:0] asid;
    logic [VPN_WD-1:0]  vpn;
    logic [PPN_WD-1:0]  ppn;
    logic [PERM_WD-1:0] perm;
    logic               is_super;
  } tlb_entry_t;

  // VPN compare; a megapage ignores VPN0.
  function automatic logic vpn_match(input logic [VPN_WD-1:0] a,
                                     input logic [VPN_WD-1:0] b,
                                     input logic is_super);
    return (a[VPN_WD-1:VPN0_WD] == b[VPN_WD-1:VPN0_WD]) &&
           (is_super || (a[VPN0_WD-1:0] == b[VPN0_WD-1:0]));
  endfunction

endpackage

`endif

// File: rtl/sv32_tlb_victim_sel.sv
// Fill slot chooser: lowest-index invalid entry, else the round-robin pointer.
// Ports: valid (per-entry valid after flush), ptr (victim pointer),
//        idx_c (write index), ptr_advance_c (1 when the pointer slot is used).
module sv32_tlb_victim_sel #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx_c,
  output logic               ptr_advance_c
);

  // Scan downward so the last assignment is the lowest free slot.
  always_comb begin
    idx_c         = ptr;
    ptr_advance_c = 1'b1;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        idx_c         = IDX_W'(i);
        ptr_advance_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sv32_tlb.sv
// Fully-associative Sv32 TLB with one-cycle registered lookup, walker refill
// and sfence.vma flush. Supplies the physical tag to the downstream cache.
// Ports: req_* lookup in; resp_* registered result (resp_ptag = resp_ppn[19:0]);
//        fill_* walker refill; flush_* sfence.vma; miss_cnt wrapping miss count.
module sv32_tlb
  import sv32_tlb_pkg::*;
#(
  parameter int unsigned ENTRIES = TLB_ENTRY_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic [VPN_WD-1:0]       req_vpn,
  input  logic [ASID_WD-1:0]      req_asid,
  output logic                    resp_valid,
  output logic                    resp_hit,
  output logic [PPN_WD-1:0]       resp_ppn,
  output logic [CACHE_TAG_WD-1:0] resp_ptag,
  output logic [PERM_WD-1:0]      resp_perm,
  input  logic                    fill_valid,
  input  logic [VPN_WD-1:0]       fill_vpn,
  input  logic [ASID_WD-1:0]      fill_asid,
  input  logic [PPN_WD-1:0]       fill_ppn,
  input  logic [PERM_WD-1:0]      fill_perm,
  input  logic                    fill_super,
  input  logic                    flush_valid,
  input  logic                    flush_use_asid,
  input  logic                    flush_use_vpn,
  input  logic [ASID_WD-1:0]      flush_asid,
  input  logic [VPN_WD-1:0]       flush_vpn,
  output logic [31:0]             miss_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  tlb_entry_t         entry_q [ENTRIES];
  tlb_entry_t         entry_d [ENTRIES];
  logic [ENTRIES-1:0] entry_we_c;
  logic [ENTRIES-1:0] hit_vec_c;
  logic [ENTRIES-1:0] flush_sel_c;
  logic [ENTRIES-1:0] valid_post_c;
  logic [ENTRIES-1:0] fill_match_c;
  logic [PPN_WD-1:0]  hit_ppn_c;
  logic [PERM_WD-1:0] hit_perm_c;
  logic [IDX_W-1:0]   match_idx_c;
  logic [IDX_W-1:0]   victim_idx_c;
  logic [IDX_W-1:0]   fill_idx_c;
  logic               victim_adv_c;
  logic               fill_do_c;
  tlb_entry_t         fill_ent_c;

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_hit_q, resp_hit_d;
  logic [PPN_WD-1:0]  resp_ppn_q, resp_ppn_d;
  logic [PERM_WD-1:0] resp_perm_q, resp_perm_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;

  // Lookup against the current (pre-write) contents; no bypass.
  always_comb begin
    hit_vec_c  = '0;
    hit_ppn_c  = '0;
    hit_perm_c = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_vec_c[i] = entry_q[i].valid &
                     (entry_q[i].perm[PERM_G] | (entry_q[i].asid == req_asid)) &
                     vpn_match(entry_q[i].vpn, req_vpn, entry_q[i].is_super);
      if (hit_vec_c[i]) begin
        hit_ppn_c  |= entry_q[i].is_super ?
                      {entry_q[i].ppn[PPN_WD-1:VPN0_WD], req_vpn[VPN0_WD-1:0]} :
                      entry_q[i].ppn;
        hit_perm_c |= entry_q[i].perm;
      end
    end
  end

  // Flush selection, then fill matching on the post-flush view. A global
  // entry on either side counts as overlapping so fills cannot alias.
  always_comb begin
    flush_sel_c  = '0;
    valid_post_c = '0;
    fill_match_c = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      flush_sel_c[i] = flush_valid & entry_q[i].valid &
                       (!flush_use_asid |
                        ((entry_q[i].asid == flush_asid) & !entry_q[i].perm[PERM_G])) &
                       (!flush_use_vpn |
                        vpn_match(entry_q[i].vpn, flush_vpn, entry_q[i].is_super));
      valid_post_c[i] = entry_q[i].valid & !flush_sel_c[i];
      fill_match_c[i] = valid_post_c[i] & (entry_q[i].is_super == fill_super) &
                        vpn_match(entry_q[i].vpn, fill_vpn, fill_super) &
                        ((entry_q[i].asid == fill_asid) |
                         entry_q[i].perm[PERM_G] | fill_perm[PERM_G]);
    end
  end

  // Lowest matching index.
  always_comb begin
    match_idx_c = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (fill_match_c[i]) match_idx_c = IDX_W'(i);
    end
  end

  sv32_tlb_victim_sel #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_victim_sel (
    .valid         (valid_post_c),
    .ptr           (ptr_q),
    .idx_c         (victim_idx_c),
    .ptr_advance_c (victim_adv_c)
  );

  // Entry next-state: flush clears, a fill on the same slot wins.
  always_comb begin
    fill_do_c           = fill_valid & fill_perm[PERM_V];
    fill_idx_c          = (|fill_match_c) ? match_idx_c : victim_idx_c;
    fill_ent_c.valid    = 1'b1;
    fill_ent_c.asid     = fill_asid;
    fill_ent_c.vpn      = fill_vpn;
    fill_ent_c.ppn      = fill_ppn;
    fill_ent_c.perm     = fill_perm;
    fill_ent_c.is_super = fill_super;
    ptr_d = (fill_do_c & !(|fill_match_c) & victim_adv_c) ? ptr_q + IDX_W'(1) : ptr_q;
    for (int i = 0; i < ENTRIES; i++) begin
      entry_d[i]    = entry_q[i];
      entry_we_c[i] = 1'b0;
      if (flush_sel_c[i]) begin
        entry_d[i].valid = 1'b0;
        entry_we_c[i]    = 1'b1;
      end
      if (fill_do_c && (fill_idx_c == IDX_W'(i))) begin
        entry_d[i]    = fill_ent_c;
        entry_we_c[i] = 1'b1;
      end
    end
  end

  // Response and miss counter next-state.
  always_comb begin
    resp_valid_d = req_valid;
    resp_hit_d   = |hit_vec_c;
    resp_ppn_d   = hit_ppn_c;
    resp_perm_d  = hit_perm_c;
    miss_cnt_d   = miss_cnt_q + 32'd1;
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    tlb_entry_t ent_q;
    `D_FLIP_FLOP(ent_q, entry_d[g], entry_we_c[g], '0)
    assign entry_q[g] = ent_q;
  end

  `D_FLIP_FLOP(ptr_q, ptr_d, 1'b1, '0)
  `D_FLIP_FLOP(resp_valid_q, resp_valid_d, 1'b1, 1'b0)
  `D_FLIP_FLOP(resp_hit_q, resp_hit_d, req_valid, 1'b0)
  `D_FLIP_FLOP(resp_ppn_q, resp_ppn_d, req_valid, '0)
  `D_FLIP_FLOP(resp_perm_q, resp_perm_d, req_valid, '0)
  `D_FLIP_FLOP(miss_cnt_q, miss_cnt_d, req_valid & !(|hit_vec_c), '0)

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_ppn   = resp_ppn_q;
  assign resp_ptag  = resp_ppn_q[CACHE_TAG_WD-1:0];
  assign resp_perm  = resp_perm_q;
  assign miss_cnt   = miss_cnt_q;

  a_hit_onehot: assert property (@(posedge clk) disable iff (!rst)
                                 req_valid |-> $onehot0(hit_vec_c))
    else $error("sv32_tlb: more than one entry hit");

endmodule

// File: tb/tb_sv32_tlb.sv
module tb_sv32_tlb;
  import sv32_tlb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic [19:0] req_vpn = '0;
  logic [8:0]  req_asid = '0;
  logic        resp_valid, resp_hit;
  logic [21:0] resp_ppn;
  logic [19:0] resp_ptag;
  logic [7:0]  resp_perm;
  logic        fill_valid = 1'b0;
  logic [19:0] fill_vpn = '0;
  logic [8:0]  fill_asid = '0;
  logic [21:0] fill_ppn = '0;
  logic [7:0]  fill_perm = '0;
  logic        fill_super = 1'b0;
  logic        flush_valid = 1'b0;
  logic        flush_use_asid = 1'b0;
  logic        flush_use_vpn = 1'b0;
  logic [8:0]  flush_asid = '0;
  logic [19:0] flush_vpn = '0;
  logic [31:0] miss_cnt;

  always #5 clk = ~clk;

  sv32_tlb dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_vpn(req_vpn), .req_asid(req_asid),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_ppn(resp_ppn),
    .resp_ptag(resp_ptag), .resp_perm(resp_perm),
    .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_asid(fill_asid),
    .fill_ppn(fill_ppn), .fill_perm(fill_perm), .fill_super(fill_super),
    .flush_valid(flush_valid), .flush_use_asid(flush_use_asid),
    .flush_use_vpn(flush_use_vpn), .flush_asid(flush_asid), .flush_vpn(flush_vpn),
    .miss_cnt(miss_cnt)
  );

  localparam int unsigned K_LOOK  = 0;
  localparam int unsigned K_FILL  = 1;
  localparam int unsigned K_FLUSH = 2;

  typedef struct {
    int unsigned kind;
    logic [19:0] vpn;
    logic [8:0]  asid;
    logic [21:0] ppn;
    logic [7:0]  perm;
    logic        sup;
    logic        use_asid;
    logic        use_vpn;
    logic        exp_hit;
    logic [21:0] exp_ppn;
    logic [7:0]  exp_perm;
  } vec_t;

  typedef struct {
    logic        hit;
    logic [21:0] ppn;
    logic [7:0]  perm;
    logic [31:0] miss;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  vec_t        tab[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_miss = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
    end
  endtask

  function automatic vec_t mk(input int unsigned kind, input logic [19:0] vpn,
                              input logic [8:0] asid, input logic [21:0] ppn,
                              input logic [7:0] perm, input logic sup,
                              input logic ua, input logic uv, input logic hit,
                              input logic [21:0] eppn, input logic [7:0] eperm);
    vec_t v;
    v.kind = kind; v.vpn = vpn; v.asid = asid; v.ppn = ppn; v.perm = perm;
    v.sup = sup; v.use_asid = ua; v.use_vpn = uv; v.exp_hit = hit;
    v.exp_ppn = eppn; v.exp_perm = eperm;
    return v;
  endfunction

  function automatic vec_t lk(input logic [19:0] vpn, input logic [8:0] asid,
                              input logic hit, input logic [21:0] ppn, input logic [7:0] perm);
    return mk(K_LOOK, vpn, asid, '0, '0, 1'b0, 1'b0, 1'b0, hit, ppn, perm);
  endfunction

  function automatic vec_t fl(input logic [19:0] vpn, input logic [8:0] asid,
                              input logic [21:0] ppn, input logic [7:0] perm, input logic sup);
    return mk(K_FILL, vpn, asid, ppn, perm, sup, 1'b0, 1'b0, 1'b0, '0, '0);
  endfunction

  function automatic vec_t fs(input logic ua, input logic uv,
                              input logic [8:0] asid, input logic [19:0] vpn);
    return mk(K_FLUSH, vpn, asid, '0, '0, 1'b0, ua, uv, 1'b0, '0, '0);
  endfunction

  task automatic idle();
    req_valid = 1'b0; fill_valid = 1'b0; flush_valid = 1'b0;
  endtask

  task automatic expect_resp(input logic hit, input logic [21:0] ppn, input logic [7:0] perm);
    exp_t e;
    if (!hit) exp_miss = exp_miss + 32'd1;
    e.hit = hit; e.ppn = ppn; e.perm = hit ? perm : 8'h00; e.miss = exp_miss;
    sb.push_back(e);
  endtask

  task automatic apply(input vec_t v);
    @(posedge clk); #1;
    idle();
    case (v.kind)
      K_LOOK: begin
        req_valid = 1'b1; req_vpn = v.vpn; req_asid = v.asid;
        expect_resp(v.exp_hit, v.exp_ppn, v.exp_perm);
      end
      K_FILL: begin
        fill_valid = 1'b1; fill_vpn = v.vpn; fill_asid = v.asid;
        fill_ppn = v.ppn; fill_perm = v.perm; fill_super = v.sup;
      end
      default: begin
        flush_valid = 1'b1; flush_use_asid = v.use_asid; flush_use_vpn = v.use_vpn;
        flush_asid = v.asid; flush_vpn = v.vpn;
      end
    endcase
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      idle();
    end
  endtask

  // Scoreboard: every response is matched against the oldest pending lookup.
  always @(negedge clk) begin
    if (rst && resp_valid) begin
      if (sb.size() == 0) begin
        chk("resp_without_req", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_hit", 32'(resp_hit), 32'(mon_e.hit));
        chk("resp_perm", 32'(resp_perm), 32'(mon_e.perm));
        chk("miss_cnt", miss_cnt, mon_e.miss);
        if (mon_e.hit) begin
          chk("resp_ppn", 32'(resp_ppn), 32'(mon_e.ppn));
          chk("resp_ptag", 32'(resp_ptag), 32'(mon_e.ppn[19:0]));
        end
      end
    end
  end

  initial begin
    // Basic translate, ASID separation, megapage, V=0 fill, overwrite.
    tab.push_back(lk(20'h12345, 9'd1, 1'b0, '0, '0));
    tab.push_back(fl(20'h12345, 9'd1, 22'h0ABCDE, 8'hCF, 1'b0));
    tab.push_back(lk(20'h12345, 9'd1, 1'b1, 22'h0ABCDE, 8'hCF));
    tab.push_back(lk(20'h12345, 9'd2, 1'b0, '0, '0));
    tab.push_back(fl(20'h40000, 9'd3, 22'h3FF000, 8'hE3, 1'b1));
    tab.push_back(lk(20'h40155, 9'd7, 1'b1, 22'h3FF155, 8'hE3));
    tab.push_back(fl(20'h0AAAA, 9'd1, 22'h000001, 8'hCE, 1'b0));
    tab.push_back(lk(20'h0AAAA, 9'd1, 1'b0, '0, '0));
    tab.push_back(fl(20'h12345, 9'd1, 22'h155555, 8'hC7, 1'b0));
    tab.push_back(lk(20'h12345, 9'd1, 1'b1, 22'h155555, 8'hC7));
    // Capacity and round-robin replacement from an empty array.
    tab.push_back(fs(1'b0, 1'b0, '0, '0));
    for (int i = 0; i < 33; i++)
      tab.push_back(fl(20'h00100 + 20'(i), 9'd1, 22'h01000 + 22'(i), 8'hC7, 1'b0));
    tab.push_back(lk(20'h00100, 9'd1, 1'b0, '0, '0));
    tab.push_back(lk(20'h00101, 9'd1, 1'b1, 22'h01001, 8'hC7));
    tab.push_back(lk(20'h00120, 9'd1, 1'b1, 22'h01020, 8'hC7));
    tab.push_back(fl(20'h00121, 9'd1, 22'h01021, 8'hC7, 1'b0));
    tab.push_back(lk(20'h00101, 9'd1, 1'b0, '0, '0));
    tab.push_back(lk(20'h00102, 9'd1, 1'b1, 22'h01002, 8'hC7));
    tab.push_back(lk(20'h00121, 9'd1, 1'b1, 22'h01021, 8'hC7));
    // Global megapage lands on the pointer slot (vpn 0x102).
    tab.push_back(fl(20'h40000, 9'd3, 22'h3FF000, 8'hE3, 1'b1));
    tab.push_back(lk(20'h00102, 9'd1, 1'b0, '0, '0));
    tab.push_back(lk(20'h40155, 9'd7, 1'b1, 22'h3FF155, 8'hE3));
    // ASID flush keeps globals; full flush clears everything.
    tab.push_back(fs(1'b1, 1'b0, 9'd1, '0));
    tab.push_back(lk(20'h00105, 9'd1, 1'b0, '0, '0));
    tab.push_back(lk(20'h00121, 9'd1, 1'b0, '0, '0));
    tab.push_back(lk(20'h40000, 9'd1, 1'b1, 22'h3FF000, 8'hE3));
    tab.push_back(fs(1'b0, 1'b0, '0, '0));
    tab.push_back(lk(20'h40155, 9'd7, 1'b0, '0, '0));
    // VPN-selective flush, including megapage VPN1-only matching.
    tab.push_back(fl(20'h00200, 9'd4, 22'h2AAAA, 8'hC7, 1'b0));
    tab.push_back(fl(20'h00201, 9'd4, 22'h2BBBB, 8'hC7, 1'b0));
    tab.push_back(fs(1'b0, 1'b1, '0, 20'h00200));
    tab.push_back(lk(20'h00200, 9'd4, 1'b0, '0, '0));
    tab.push_back(lk(20'h00201, 9'd4, 1'b1, 22'h2BBBB, 8'hC7));
    tab.push_back(fl(20'h40000, 9'd3, 22'h3FF000, 8'hE3, 1'b1));
    tab.push_back(lk(20'h40155, 9'd7, 1'b1, 22'h3FF155, 8'hE3));
    tab.push_back(fs(1'b0, 1'b1, '0, 20'h403FF));
    tab.push_back(lk(20'h40155, 9'd7, 1'b0, '0, '0));

    idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_resp_ppn", 32'(resp_ppn), 32'd0);
    chk("rst_resp_perm", 32'(resp_perm), 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b1;

    foreach (tab[i]) apply(tab[i]);

    // Lookup, fill and flush-all of the same VPN in one cycle.
    @(posedge clk); #1;
    idle();
    req_valid = 1'b1; req_vpn = 20'h00300; req_asid = 9'd5;
    fill_valid = 1'b1; fill_vpn = 20'h00300; fill_asid = 9'd5;
    fill_ppn = 22'h3CCCC; fill_perm = 8'hC7; fill_super = 1'b0;
    flush_valid = 1'b1; flush_use_asid = 1'b0; flush_use_vpn = 1'b0;
    expect_resp(1'b0, '0, '0);
    apply(lk(20'h00300, 9'd5, 1'b1, 22'h3CCCC, 8'hC7));
    apply(lk(20'h00201, 9'd4, 1'b0, '0, '0));
    idle_cycles(3);
    chk("drain_before_reset", 32'(sb.size()), 32'd0);

    // Reset while a lookup is in flight: its response is dropped.
    @(posedge clk); #1;
    idle();
    req_valid = 1'b1; req_vpn = 20'h00300; req_asid = 9'd5;
    @(negedge clk);
    rst = 1'b0;
    #1 idle();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_resp_hit", 32'(resp_hit), 32'd0);
    chk("midrst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b1;
    exp_miss = '0;
    apply(lk(20'h00300, 9'd5, 1'b0, '0, '0));
    idle_cycles(3);
    chk("final_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
